control_multi: RTL and testbench
================================

// Module: control_multi
// PURPOSE
//  Multicycle RV32I main controller (FSM) for riscy32_multi. Decodes op/funct3/funct7, sequences
//  fetch/decode/execute/mem/writeback over a shared memory and a single ALU. Adds jalr, auipc,
//  memory wait-states, an illegal-op trap and a retire pulse. Sits beside the datapath and drives
//  all of its mux selects and write enables.
// PARAMETERS
//  MEM_WAIT   1  1: honour mem_ready in FETCH/MEMREAD/MEMWRITE; 0: mem_ready ignored, treated as 1
//  EN_JALR    1  1: jalr decoded; 0: opcode 1100111 traps as illegal
//  EN_AUIPC   1  1: auipc decoded; 0: opcode 0010111 traps as illegal
//  ALUCTRL_W  4  ALUControl width; encoding {funct7[5],funct3}; ADD=0, SUB=8
// PORTS
//  clk         in   1          clock
//  rst         in   1          asynchronous, active-high reset
//  op          in   7          instr[6:0], taken from the IR
//  funct3      in   3          instr[14:12]
//  funct7      in   1          instr[30]
//  flags       in   4          ALU {N,Z,C,V} = {3,2,1,0}, combinational, current cycle
//  mem_ready   in   1          memory access completes this cycle
//  PCWrite     out  1          PC <= Result
//  AdrSrc      out  1          0: address from PC; 1: address from ALUOut
//  IRWrite     out  1          IR <= rdata and OldPC <= PC
//  MemWrite    out  1          store strobe
//  RegWrite    out  1          rd <= Result
//  ResultSrc   out  2          00 ALUOut, 01 mem data, 10 ALU result (live)
//  ALUSrcA     out  2          00 PC, 01 OldPC, 10 rs1, 11 zero
//  ALUSrcB     out  2          00 rs2, 01 imm, 10 const 4
//  ImmSrc      out  3          000 I, 001 S, 010 B, 011 J, 100 U
//  ALUControl  out  ALUCTRL_W  ALU operation
//  illegal     out  1          sticky; set on undecodable op
//  retire      out  1          1-cycle pulse in the last state of each instruction
// BEHAVIOUR
//  Moore FSM. States: FETCH DECODE MEMADR MEMREAD MEMWB MEMWRITE EXECR EXECI EXECU BRANCH JAL JALR
//   ALUWB TRAP. rst -> FETCH asynchronously. While rst is high and in FETCH before any mem_ready,
//   all enables (PCWrite, IRWrite, MemWrite, RegWrite, retire, illegal) are 0 and all selects are 0.
//  Defaults in every state: all enables 0, ALUControl=ADD, selects 0 unless listed below.
//  FETCH: AdrSrc=0, A=00, B=10, ResultSrc=10. IRWrite=PCWrite=mem_ready. Go to DECODE on
//   mem_ready, otherwise stay in FETCH.
//  DECODE: A=01, B=01, ImmSrc=B (ALUOut <= OldPC+immB). Next state by op: 0000011/0100011 -> MEMADR;
//   0110011 -> EXECR; 0010011 -> EXECI; 0110111/0010111 -> EXECU; 1100011 -> BRANCH; 1101111 -> JAL;
//   1100111 -> JALR. Disabled or unknown op -> TRAP.
//  MEMADR: A=10, B=01, ImmSrc = I for loads, S for stores -> MEMREAD (load) or MEMWRITE (store).
//  MEMREAD: AdrSrc=1. Stay until mem_ready, then MEMWB.
//  MEMWB: ResultSrc=01, RegWrite=1, retire=1 -> FETCH.
//  MEMWRITE: AdrSrc=1, MemWrite=1 held until mem_ready. Exit cycle: retire=1 -> FETCH.
//  EXECR: A=10, B=00, ALUControl={funct7,funct3} -> ALUWB.
//  EXECI: A=10, B=01, ImmSrc=I. ALUControl={funct7,funct3} for funct3 1/5, else {0,funct3} -> ALUWB.
//  EXECU: ImmSrc=U, B=01. A=11 for lui, A=01 for auipc -> ALUWB.
//  ALUWB: ResultSrc=00, RegWrite=1, retire=1 -> FETCH.
//  BRANCH: A=10, B=00, ALUControl=SUB, ResultSrc=00. PCWrite=taken, retire=1 -> FETCH.
//   taken by funct3: 0 Z; 1 !Z; 4 N^V; 5 !(N^V); 6 !C; 7 C; funct3 2/3 -> TRAP, no PCWrite.
//  JALR: A=10, B=01, ImmSrc=I (ALUOut <= rs1+imm) -> JAL.
//  JAL: A=01, B=10, ResultSrc=00, PCWrite=1 (PC <= ALUOut; ALUOut <= OldPC+4) -> ALUWB.
//  TRAP: illegal=1 is held; no enables asserted; the FSM stays in TRAP until rst.
//  Latency from FETCH accept: R/I/U/jal 4 cycles, jalr 5, load 5, store 4, branch 3; each wait
//   cycle adds 1.
//  Reset mid-instruction aborts without completing any pending PC/reg/mem write. mem_ready outside
//   FETCH/MEMREAD/MEMWRITE is ignored.
// STRUCTURE
//  riscy_pkg: opcode localparams, state_t enum, ALU codes (ADD, SUB), ImmSrc/ALUSrcA/ALUSrcB/
//   ResultSrc codes; shared with the datapath.
//  Sub-module branch_cond (funct3, flags -> taken, valid), combinational; also reusable by the
//   single-cycle core.
//  Structure: state register in always_ff; next state and outputs in always_comb; no latches.
// TESTING
//  add (0110011, f3=0, f7=0), mem_ready=1: state sequence FETCH,DECODE,EXECR,ALUWB;
//   RegWrite=1 only in cycle 4; retire pulses once.
//  lw with mem_ready low 2 cycles in MEMREAD: MEMREAD lasts 3 cycles, AdrSrc=1 throughout;
//   MEMWB gives ResultSrc=01 and RegWrite=1.
//  beq with flags=4'b0100: PCWrite=1 in BRANCH. bltu with flags=4'b0010: PCWrite=0.
//   bge with flags=4'b1001: PCWrite=1.
//  jalr: DECODE,JALR,JAL,ALUWB; PCWrite only in JAL; RegWrite only in ALUWB.
//  op=7'b1111111, and op=0010111 with EN_AUIPC=0: TRAP, illegal=1 held for 10 cycles;
//   rst clears it and the FSM is back in FETCH.
//  rst asserted mid-MEMWRITE with mem_ready=0: MemWrite drops immediately (asynchronous),
//   the FSM is in FETCH after release, no RegWrite or PCWrite.

Source files
------------

// File: rtl/control_multi_pkg.sv
// Shared encodings for the riscy32_multi controller and datapath: opcodes, FSM states,
// ALU operation codes and the mux-select codes the controller drives.
package control_multi_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_EXECU    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_ALUWB    = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd8;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/control_multi_branch_cond.sv
// Branch condition evaluator: funct3 and ALU flags {N,Z,C,V} -> taken, plus valid for
// the six defined RV32I branch encodings.
module branch_cond
    import control_multi_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic [3:0] flags_i,
    output logic       taken_o,
    output logic       valid_o
);

    // Flags come from rs1 - rs2, so signed compares use N^V and unsigned use the carry.
    always_comb begin
        taken_o = 1'b0;
        valid_o = 1'b1;
        case (funct3_i)
            3'd0:    taken_o = flags_i[FLAG_Z];
            3'd1:    taken_o = ~flags_i[FLAG_Z];
            3'd4:    taken_o = flags_i[FLAG_N] ^ flags_i[FLAG_V];
            3'd5:    taken_o = ~(flags_i[FLAG_N] ^ flags_i[FLAG_V]);
            3'd6:    taken_o = ~flags_i[FLAG_C];
            3'd7:    taken_o = flags_i[FLAG_C];
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_multi.sv
// Multicycle RV32I main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback
// over a shared memory and single ALU, with wait-states, jalr/auipc, illegal-op trap and retire.
module control_multi
    import control_multi_pkg::*;
#(
    parameter int MEM_WAIT  = 1,
    parameter int EN_JALR   = 1,
    parameter int EN_AUIPC  = 1,
    parameter int ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7,
    input  logic [3:0]           flags,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [2:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 illegal,
    output logic                 retire
);

    state_t     state_q, state_d;
    logic       mem_ok_s;
    logic       br_taken_s, br_valid_s;
    logic       pc_write_s, adr_src_s, ir_write_s, mem_write_s, reg_write_s;
    logic       illegal_s, retire_s;
    logic [1:0] result_src_s, alu_src_a_s, alu_src_b_s;
    logic [2:0] imm_src_s;
    logic [3:0] alu_ctrl_s;

    assign mem_ok_s = (MEM_WAIT != 0) ? mem_ready : 1'b1;

    branch_cond u_branch_cond (
        .funct3_i (funct3),
        .flags_i  (flags),
        .taken_o  (br_taken_s),
        .valid_o  (br_valid_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control outputs.
    always_comb begin
        state_d      = state_q;
        pc_write_s   = 1'b0;
        adr_src_s    = 1'b0;
        ir_write_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        illegal_s    = 1'b0;
        retire_s     = 1'b0;
        result_src_s = RES_ALUOUT;
        alu_src_a_s  = SRCA_PC;
        alu_src_b_s  = SRCB_RS2;
        imm_src_s    = IMM_I;
        alu_ctrl_s   = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                alu_src_b_s  = SRCB_FOUR;
                result_src_s = RES_ALU;
                ir_write_s   = mem_ok_s;
                pc_write_s   = mem_ok_s;
                if (mem_ok_s) state_d = S_DECODE;
                else          state_d = S_FETCH;
            end
            S_DECODE: begin
                alu_src_a_s = SRCA_OLDPC;
                alu_src_b_s = SRCB_IMM;
                imm_src_s   = IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_LUI:            state_d = S_EXECU;
                    OP_AUIPC:          state_d = (EN_AUIPC != 0) ? S_EXECU : S_TRAP;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = (EN_JALR != 0) ? S_JALR : S_TRAP;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_IMM;
                if (op == OP_LOAD) begin
                    imm_src_s = IMM_I;
                    state_d   = S_MEMREAD;
                end else begin
                    imm_src_s = IMM_S;
                    state_d   = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                adr_src_s = 1'b1;
                if (mem_ok_s) state_d = S_MEMWB;
                else          state_d = S_MEMREAD;
            end
            S_MEMWB: begin
                result_src_s = RES_MEM;
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
                retire_s    = mem_ok_s;
                if (mem_ok_s) state_d = S_FETCH;
                else          state_d = S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a_s = SRCA_RS1;
                alu_ctrl_s  = {funct7, funct3};
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                // Only shifts carry a meaningful funct7 bit in I-type; elsewhere it is immediate.
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_IMM;
                if ((funct3 == 3'd1) || (funct3 == 3'd5)) alu_ctrl_s = {funct7, funct3};
                else                                      alu_ctrl_s = {1'b0, funct3};
                state_d = S_ALUWB;
            end
            S_EXECU: begin
                imm_src_s   = IMM_U;
                alu_src_b_s = SRCB_IMM;
                if (op == OP_LUI) alu_src_a_s = SRCA_ZERO;
                else              alu_src_a_s = SRCA_OLDPC;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                retire_s    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_s = SRCA_RS1;
                alu_ctrl_s  = ALU_SUB;
                if (br_valid_s) begin
                    pc_write_s = br_taken_s;
                    retire_s   = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_JALR: begin
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_IMM;
                state_d     = S_JAL;
            end
            S_JAL: begin
                alu_src_a_s = SRCA_OLDPC;
                alu_src_b_s = SRCB_FOUR;
                pc_write_s  = 1'b1;
                state_d     = S_ALUWB;
            end
            S_TRAP: begin
                illegal_s = 1'b1;
                state_d   = S_TRAP;
            end
            // Unreachable encodings are treated as corruption and parked in the trap.
            default: state_d = S_TRAP;
        endcase
    end

    // Reset forces every strobe and select low so no partial write can escape an abort.
    always_comb begin
        if (rst) begin
            PCWrite    = 1'b0;
            AdrSrc     = 1'b0;
            IRWrite    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            ResultSrc  = 2'b00;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ImmSrc     = 3'b000;
            ALUControl = '0;
            illegal    = 1'b0;
            retire     = 1'b0;
        end else begin
            PCWrite    = pc_write_s;
            AdrSrc     = adr_src_s;
            IRWrite    = ir_write_s;
            MemWrite   = mem_write_s;
            RegWrite   = reg_write_s;
            ResultSrc  = result_src_s;
            ALUSrcA    = alu_src_a_s;
            ALUSrcB    = alu_src_b_s;
            ImmSrc     = imm_src_s;
            ALUControl = ALUCTRL_W'(alu_ctrl_s);
            illegal    = illegal_s;
            retire     = retire_s;
        end
    end

endmodule

// File: tb/tb_control_multi.sv
// Scoreboard bench for control_multi: a default instance and one with auipc disabled share
// stimulus; each cycle's expected output vectors are queued and checked on the falling edge.
module tb_control_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7 = 1'b0;
    logic [3:0] flags = 4'd0;
    logic       mem_ready = 1'b0;

    logic [6:0] n_op = 7'd0;
    logic [2:0] n_f3 = 3'd0;
    logic       n_f7 = 1'b0;
    logic [3:0] n_fl = 4'd0;

    logic       pcw0, adr0, irw0, mw0, rw0, ill0, ret0;
    logic [1:0] rs0, sa0, sb0;
    logic [2:0] imm0;
    logic [3:0] alu0;
    logic       pcw1, adr1, irw1, mw1, rw1, ill1, ret1;
    logic [1:0] rs1, sa1, sb1;
    logic [2:0] imm1;
    logic [3:0] alu1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [19:0] e0;
        logic [19:0] e1;
        string       name;
    } exp_t;
    exp_t sbq[$];

    logic [19:0] act0, act1;
    assign act0 = {pcw0, adr0, irw0, mw0, rw0, rs0, sa0, sb0, imm0, alu0, ill0, ret0};
    assign act1 = {pcw1, adr1, irw1, mw1, rw1, rs1, sa1, sb1, imm1, alu1, ill1, ret1};

    control_multi dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .flags(flags),
        .mem_ready(mem_ready), .PCWrite(pcw0), .AdrSrc(adr0), .IRWrite(irw0), .MemWrite(mw0),
        .RegWrite(rw0), .ResultSrc(rs0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ImmSrc(imm0),
        .ALUControl(alu0), .illegal(ill0), .retire(ret0)
    );

    control_multi #(.EN_AUIPC(0)) dut_na (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .flags(flags),
        .mem_ready(mem_ready), .PCWrite(pcw1), .AdrSrc(adr1), .IRWrite(irw1), .MemWrite(mw1),
        .RegWrite(rw1), .ResultSrc(rs1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ImmSrc(imm1),
        .ALUControl(alu1), .illegal(ill1), .retire(ret1)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] mk(input logic pcw, adr, irw, mw, rw,
                                       input logic [1:0] rs, a, b, input logic [2:0] imm,
                                       input logic [3:0] alu, input logic ill, ret);
        return {pcw, adr, irw, mw, rw, rs, a, b, imm, alu, ill, ret};
    endfunction

    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic [3:0] fl);
        n_op = o; n_f3 = f3; n_f7 = f7; n_fl = fl;
    endtask

    // e1 is the expectation for the auipc-disabled instance; same as e0 unless use_e1.
    task automatic step(input string nm, input logic r, input logic rdy, input logic [19:0] e0,
                        input logic [19:0] e1 = 20'd0, input bit use_e1 = 1'b0);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; mem_ready = rdy;
        op = n_op; funct3 = n_f3; funct7 = n_f7; flags = n_fl;
        e.e0 = e0;
        e.e1 = use_e1 ? e1 : e0;
        e.name = nm;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            n_checks++;
            if (act0 !== e.e0) begin
                n_fail++;
                $display("FAIL %s dut: got %h expected %h", e.name, act0, e.e0);
            end
            n_checks++;
            if (act1 !== e.e1) begin
                n_fail++;
                $display("FAIL %s dut_na: got %h expected %h", e.name, act1, e.e1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] X_ZERO, X_FETCH, X_FETCH_W, X_DECODE, X_ALUWB, X_TRAP, X_RS1_IMM;
        logic [19:0] X_MEMADR_S, X_MEMRD, X_MEMWB, X_MEMW, X_MEMW_DONE, X_JAL;
        int drain;
        X_ZERO      = 20'd0;
        X_FETCH     = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 4'h0, 1'b0, 1'b0);
        X_FETCH_W   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 4'h0, 1'b0, 1'b0);
        X_DECODE    = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b010, 4'h0, 1'b0, 1'b0);
        X_ALUWB     = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0, 1'b0, 1'b1);
        X_TRAP      = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0, 1'b1, 1'b0);
        X_RS1_IMM   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 4'h0, 1'b0, 1'b0);
        X_MEMADR_S  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b001, 4'h0, 1'b0, 1'b0);
        X_MEMRD     = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0, 1'b0, 1'b0);
        X_MEMWB     = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 4'h0, 1'b0, 1'b1);
        X_MEMW      = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0, 1'b0, 1'b0);
        X_MEMW_DONE = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0, 1'b0, 1'b1);
        X_JAL       = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 4'h0, 1'b0, 1'b0);

        step("reset_hold", 1'b1, 1'b1, X_ZERO);

        instr(7'b0110011, 3'd0, 1'b0, 4'd0);
        step("add_fetch_wait", 1'b0, 1'b0, X_FETCH_W);
        step("add_fetch", 1'b0, 1'b1, X_FETCH);
        step("add_decode", 1'b0, 1'b1, X_DECODE);
        step("add_execr", 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 4'h0, 1'b0, 1'b0));
        step("add_aluwb", 1'b0, 1'b0, X_ALUWB);

        instr(7'b0110011, 3'd0, 1'b1, 4'd0);
        step("sub_fetch", 1'b0, 1'b1, X_FETCH);
        step("sub_decode", 1'b0, 1'b0, X_DECODE);
        step("sub_execr", 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 4'h8, 1'b0, 1'b0));
        step("sub_aluwb", 1'b0, 1'b0, X_ALUWB);

        instr(7'b0010011, 3'd5, 1'b1, 4'd0);
        step("srai_fetch", 1'b0, 1'b1, X_FETCH);
        step("srai_decode", 1'b0, 1'b0, X_DECODE);
        step("srai_execi", 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 4'hd, 1'b0, 1'b0));
        step("srai_aluwb", 1'b0, 1'b0, X_ALUWB);

        instr(7'b0010011, 3'd0, 1'b1, 4'd0);
        step("addi_fetch", 1'b0, 1'b1, X_FETCH);
        step("addi_decode", 1'b0, 1'b0, X_DECODE);
        step("addi_execi_f7_ignored", 1'b0, 1'b0, X_RS1_IMM);
        step("addi_aluwb", 1'b0, 1'b0, X_ALUWB);

        instr(7'b0000011, 3'd2, 1'b0, 4'd0);
        step("lw_fetch", 1'b0, 1'b1, X_FETCH);
        step("lw_decode", 1'b0, 1'b0, X_DECODE);
        step("lw_memadr", 1'b0, 1'b1, X_RS1_IMM);
        step("lw_memread_w1", 1'b0, 1'b0, X_MEMRD);
        step("lw_memread_w2", 1'b0, 1'b0, X_MEMRD);
        step("lw_memread_go", 1'b0, 1'b1, X_MEMRD);
        step("lw_memwb", 1'b0, 1'b0, X_MEMWB);

        instr(7'b0100011, 3'd2, 1'b0, 4'd0);
        step("sw_fetch", 1'b0, 1'b1, X_FETCH);
        step("sw_decode", 1'b0, 1'b0, X_DECODE);
        step("sw_memadr", 1'b0, 1'b0, X_MEMADR_S);
        step("sw_memwrite_w", 1'b0, 1'b0, X_MEMW);
        step("sw_memwrite_go", 1'b0, 1'b1, X_MEMW_DONE);

        instr(7'b1100011, 3'd0, 1'b0, 4'b0100);
        step("beq_fetch", 1'b0, 1'b1, X_FETCH);
        step("beq_decode", 1'b0, 1'b0, X_DECODE);
        step("beq_taken", 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 4'h8, 1'b0, 1'b1));

        instr(7'b1100011, 3'd6, 1'b0, 4'b0010);
        step("bltu_fetch", 1'b0, 1'b1, X_FETCH);
        step("bltu_decode", 1'b0, 1'b0, X_DECODE);
        step("bltu_not_taken", 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 4'h8, 1'b0, 1'b1));

        instr(7'b1100011, 3'd5, 1'b0, 4'b1001);
        step("bge_fetch", 1'b0, 1'b1, X_FETCH);
        step("bge_decode", 1'b0, 1'b0, X_DECODE);
        step("bge_taken", 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 4'h8, 1'b0, 1'b1));

        instr(7'b1100111, 3'd0, 1'b0, 4'd0);
        step("jalr_fetch", 1'b0, 1'b1, X_FETCH);
        step("jalr_decode", 1'b0, 1'b0, X_DECODE);
        step("jalr_jalr", 1'b0, 1'b0, X_RS1_IMM);
        step("jalr_jal", 1'b0, 1'b0, X_JAL);
        step("jalr_aluwb", 1'b0, 1'b0, X_ALUWB);

        instr(7'b0110111, 3'd0, 1'b0, 4'd0);
        step("lui_fetch", 1'b0, 1'b1, X_FETCH);
        step("lui_decode", 1'b0, 1'b0, X_DECODE);
        step("lui_execu", 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 2'b01, 3'b100, 4'h0, 1'b0, 1'b0));
        step("lui_aluwb", 1'b0, 1'b0, X_ALUWB);

        instr(7'b0010111, 3'd0, 1'b0, 4'd0);
        step("auipc_fetch", 1'b0, 1'b1, X_FETCH);
        step("auipc_decode", 1'b0, 1'b0, X_DECODE);
        step("auipc_execu", 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b100, 4'h0, 1'b0, 1'b0), X_TRAP, 1'b1);
        step("auipc_aluwb", 1'b0, 1'b0, X_ALUWB, X_TRAP, 1'b1);

        instr(7'b1111111, 3'd0, 1'b0, 4'd0);
        step("bad_fetch", 1'b0, 1'b1, X_FETCH, X_TRAP, 1'b1);
        step("bad_decode", 1'b0, 1'b0, X_DECODE, X_TRAP, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step("trap_hold", 1'b0, 1'(i % 2), X_TRAP);
        end
        step("trap_reset", 1'b1, 1'b0, X_ZERO);
        step("trap_release", 1'b0, 1'b1, X_FETCH);

        instr(7'b1100011, 3'd2, 1'b0, 4'b0100);
        step("bf2_decode", 1'b0, 1'b0, X_DECODE);
        step("bf2_branch", 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 4'h8, 1'b0, 1'b0));
        step("bf2_trap", 1'b0, 1'b0, X_TRAP);
        step("bf2_reset", 1'b1, 1'b1, X_ZERO);

        instr(7'b0100011, 3'd2, 1'b0, 4'd0);
        step("abort_fetch", 1'b0, 1'b1, X_FETCH);
        step("abort_decode", 1'b0, 1'b0, X_DECODE);
        step("abort_memadr", 1'b0, 1'b0, X_MEMADR_S);
        step("abort_memwrite", 1'b0, 1'b0, X_MEMW);
        step("abort_reset", 1'b1, 1'b0, X_ZERO);
        instr(7'b0110011, 3'd0, 1'b0, 4'd0);
        step("abort_release", 1'b0, 1'b0, X_FETCH_W);
        step("abort_fetch2", 1'b0, 1'b1, X_FETCH);
        step("abort_decode2", 1'b0, 1'b0, X_DECODE);

        drain = 0;
        while (sbq.size() != 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        #1;
        if (sbq.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
